// File: rtl/rgb_cmp_pwm_if.sv
`default_nettype none
// ============================================================================
// Module      : rgb_cmp_pwm_if
// Description : Operand/control and LED/status bundle for rgb_cmp_pwm.
//               The master drives the operands and controls.
//               The slave (the comparator) drives the LED and status outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface rgb_cmp_pwm_if #(
    parameter int WIDTH    = 4,
    parameter int PWM_BITS = 8,
    parameter int CNT_W    = 8
);
    logic                in_valid;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] duty;
    logic                clr_cnt;
    logic                r;
    logic                g;
    logic                b_out;
    logic                eq;
    logic                out_valid;
    logic [CNT_W-1:0]    mis_count;

    modport master (
        output in_valid, a, b, mode, duty, clr_cnt,
        input  r, g, b_out, eq, out_valid, mis_count
    );

    modport slave (
        input  in_valid, a, b, mode, duty, clr_cnt,
        output r, g, b_out, eq, out_valid, mis_count
    );
endinterface
`default_nettype wire

// File: rtl/rgb_cmp_pwm.sv
`default_nettype none
// ============================================================================
// Module      : rgb_cmp_pwm
// Description : Registered unsigned magnitude comparator driving an RGB LED.
//               Red means a>=b, green means b>=a, and blue means a!=b.
//               The LED can be shown steady, PWM-dimmed, blinking or off.
//               A saturating counter records mismatched samples.
// Revision    : 1.0  initial release
// ============================================================================
module rgb_cmp_pwm #(
    parameter int WIDTH        = 4,
    parameter int PWM_BITS     = 8,
    parameter int BLINK_CYCLES = 25000000,
    parameter int CNT_W        = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rgb_cmp_pwm_if.slave  bus
);

    localparam int                     c_blink_w    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [c_blink_w-1:0]   c_blink_last = c_blink_w'(BLINK_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [1:0]             c_mode_steady = 2'b00;
    localparam logic [1:0]             c_mode_pwm    = 2'b01;
    localparam logic [1:0]             c_mode_blink  = 2'b10;

    // Captured comparison flags; these persist between samples.
    logic ge_q, ge_d, le_q, le_d, ne_q, ne_d;
    // A capture happened on the previous edge, so the outputs publish it now.
    logic cap_q, cap_d;
    logic r_q, r_d, g_q, g_d, b_q, b_d, eq_q, eq_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     mis_q, mis_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 w_gate;

    // LED enable for the current display mode.
    always_comb begin
        w_gate = 1'b0;
        case (bus.mode)
            c_mode_steady: w_gate = 1'b1;
            c_mode_pwm:    w_gate = (pwm_cnt_q < bus.duty);
            c_mode_blink:  w_gate = blink_phase_q;
            default:       w_gate = 1'b0;
        endcase
    end

    // Next-state logic for capture, outputs, counters and the blink timer.
    always_comb begin
        ge_d          = ge_q;
        le_d          = le_q;
        ne_d          = ne_q;
        mis_d         = mis_q;
        cap_d         = bus.in_valid;
        out_valid_d   = cap_q;
        // The LED colours are re-gated on every edge, so mode and duty changes appear one cycle later.
        r_d           = ge_q & w_gate;
        g_d           = le_q & w_gate;
        b_d           = ne_q & w_gate;
        // eq changes only when a new sample is published, so it reads 0 until the first sample after reset.
        eq_d          = cap_q ? ~ne_q : eq_q;
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;

        if (bus.in_valid) begin
            ge_d = (bus.a >= bus.b);
            le_d = (bus.b >= bus.a);
            ne_d = (bus.a != bus.b);
        end

        if (bus.clr_cnt) begin
            mis_d = '0;
        end else if (bus.in_valid && (bus.a != bus.b) && (mis_q != c_cnt_max)) begin
            mis_d = mis_q + 1'b1;
        end

        // Outside blink mode, the timer is held in its starting state so that entering blink mode begins a full ON half-period.
        if (bus.mode == c_mode_blink) begin
            blink_phase_d = blink_phase_q;
            if (blink_cnt_q == c_blink_last) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ge_q          <= 1'b0;
            le_q          <= 1'b0;
            ne_q          <= 1'b0;
            cap_q         <= 1'b0;
            r_q           <= 1'b0;
            g_q           <= 1'b0;
            b_q           <= 1'b0;
            eq_q          <= 1'b0;
            out_valid_q   <= 1'b0;
            mis_q         <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            ge_q          <= ge_d;
            le_q          <= le_d;
            ne_q          <= ne_d;
            cap_q         <= cap_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            eq_q          <= eq_d;
            out_valid_q   <= out_valid_d;
            mis_q         <= mis_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign bus.r         = r_q;
    assign bus.g         = g_q;
    assign bus.b_out     = b_q;
    assign bus.eq        = eq_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mis_count = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_cmp_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_cmp_pwm
// Description : Directed self-checking bench for rgb_cmp_pwm.
//               Uses WIDTH=4, PWM_BITS=4, BLINK_CYCLES=5 and CNT_W=2.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_cmp_pwm;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rgb_cmp_pwm_if #(.WIDTH(4), .PWM_BITS(4), .CNT_W(2)) bus ();

    rgb_cmp_pwm #(
        .WIDTH        (4),
        .PWM_BITS     (4),
        .BLINK_CYCLES (5),
        .CNT_W        (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and then settle, so the outputs for that edge can be read.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one sample and advance to the cycle in which it is published.
    task automatic do_sample(input logic [3:0] aa, input logic [3:0] bb);
        bus.in_valid = 1'b1;
        bus.a        = aa;
        bus.b        = bb;
        tick();
        bus.in_valid = 1'b0;
        tick();
    endtask

    function automatic logic [2:0] rgb();
        return {bus.r, bus.g, bus.b_out};
    endfunction

    initial begin
        int         cnt_r;
        int         cnt_g;
        int         cnt_b;
        logic [3:0] pa;
        logic [3:0] pb;

        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 4'd3;
        bus.b        = 4'd1;
        bus.mode     = 2'b00;
        bus.duty     = 4'd0;
        bus.clr_cnt  = 1'b0;
        pa           = 4'd0;
        pb           = 4'd0;

        // Reset is held for two edges while in_valid is asserted; the sample must be ignored.
        tick();
        tick();
        chk("rst_rgb", 32'(rgb()), 32'd0);
        chk("rst_eq", 32'(bus.eq), 32'd0);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_cnt", 32'(bus.mis_count), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("post_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("post_rst_rgb", 32'(rgb()), 32'd0);
        tick();
        chk("post_rst_ov2", 32'(bus.out_valid), 32'd0);

        // Spot values in steady mode and with the LED off.
        do_sample(4'd9, 4'd3);
        chk("spot_9_3_rgb", 32'(rgb()), 32'b101);
        chk("spot_9_3_eq", 32'(bus.eq), 32'd0);
        chk("spot_9_3_ov", 32'(bus.out_valid), 32'd1);
        tick();
        chk("spot_ov_pulse", 32'(bus.out_valid), 32'd0);
        do_sample(4'd5, 4'd5);
        chk("spot_5_5_rgb", 32'(rgb()), 32'b110);
        chk("spot_5_5_eq", 32'(bus.eq), 32'd1);
        do_sample(4'd0, 4'd15);
        chk("spot_0_15_rgb", 32'(rgb()), 32'b011);
        do_sample(4'd15, 4'd0);
        chk("spot_15_0_rgb", 32'(rgb()), 32'b101);
        bus.mode = 2'b11;
        do_sample(4'd9, 4'd3);
        chk("off_rgb", 32'(rgb()), 32'b000);
        chk("off_ov", 32'(bus.out_valid), 32'd1);
        do_sample(4'd4, 4'd4);
        chk("off_eq", 32'(bus.eq), 32'd1);
        bus.mode = 2'b00;

        // Exhaustive back-to-back sweep; each edge publishes the previous sample.
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                bus.in_valid = 1'b1;
                bus.a        = 4'(i / 16);
                bus.b        = 4'(i % 16);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (i > 0) begin
                chk("sweep_ov", 32'(bus.out_valid), 32'd1);
                chk("sweep_rgb", 32'(rgb()), 32'({pa >= pb, pb >= pa, pa != pb}));
                chk("sweep_eq", 32'(bus.eq), 32'(pa == pb));
            end
            pa = bus.a;
            pb = bus.b;
        end
        tick();
        chk("sweep_ov_end", 32'(bus.out_valid), 32'd0);

        // PWM mode: a=2, b=7 lights green and blue only.
        bus.mode = 2'b01;
        bus.duty = 4'd4;
        do_sample(4'd2, 4'd7);
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            cnt_r += int'(bus.r);
            cnt_g += int'(bus.g);
            cnt_b += int'(bus.b_out);
        end
        chk("pwm4_r", 32'(cnt_r), 32'd0);
        chk("pwm4_g", 32'(cnt_g), 32'd4);
        chk("pwm4_b", 32'(cnt_b), 32'd4);
        bus.duty = 4'd0;
        tick();
        cnt_g = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            cnt_g += int'(bus.g);
        end
        chk("pwm0_g", 32'(cnt_g), 32'd0);
        bus.duty = 4'd15;
        tick();
        cnt_g = 0; cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            cnt_g += int'(bus.g);
            cnt_b += int'(bus.b_out);
        end
        chk("pwm15_g", 32'(cnt_g), 32'd15);
        chk("pwm15_b", 32'(cnt_b), 32'd15);

        // Blink mode with a=b=0 gives 5 cycles on and 5 cycles off.
        bus.mode = 2'b00;
        do_sample(4'd0, 4'd0);
        chk("blink_pre_rgb", 32'(rgb()), 32'b110);
        bus.mode = 2'b10;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("blink_r", 32'(bus.r), 32'(((k / 5) % 2) == 0));
            chk("blink_g", 32'(bus.g), 32'(((k / 5) % 2) == 0));
            chk("blink_b", 32'(bus.b_out), 32'd0);
            chk("blink_eq", 32'(bus.eq), 32'd1);
        end
        bus.mode = 2'b00;
        tick();
        chk("blink_exit_rgb", 32'(rgb()), 32'b110);

        // Saturating mismatch counter.
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        chk("cnt_clr", 32'(bus.mis_count), 32'd0);
        do_sample(4'd1, 4'd0);
        chk("cnt_1", 32'(bus.mis_count), 32'd1);
        do_sample(4'd0, 4'd2);
        chk("cnt_2", 32'(bus.mis_count), 32'd2);
        do_sample(4'd8, 4'd3);
        chk("cnt_3", 32'(bus.mis_count), 32'd3);
        do_sample(4'd1, 4'd0);
        chk("cnt_sat4", 32'(bus.mis_count), 32'd3);
        do_sample(4'd1, 4'd0);
        chk("cnt_sat5", 32'(bus.mis_count), 32'd3);
        bus.clr_cnt = 1'b1;
        do_sample(4'd4, 4'd1);
        bus.clr_cnt = 1'b0;
        chk("cnt_clr_wins", 32'(bus.mis_count), 32'd0);
        do_sample(4'd3, 4'd2);
        chk("cnt_after_clr", 32'(bus.mis_count), 32'd1);
        do_sample(4'd6, 4'd6);
        chk("cnt_match_hold", 32'(bus.mis_count), 32'd1);

        // A reset on the edge right after a capture suppresses that sample.
        bus.in_valid = 1'b1;
        bus.a        = 4'd7;
        bus.b        = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        chk("midrst_ov", 32'(bus.out_valid), 32'd0);
        chk("midrst_rgb", 32'(rgb()), 32'd0);
        chk("midrst_eq", 32'(bus.eq), 32'd0);
        chk("midrst_cnt", 32'(bus.mis_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_ov2", 32'(bus.out_valid), 32'd0);
        chk("midrst_rgb2", 32'(rgb()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_cmp_pwm.md
Name: rgb_cmp_pwm

Overview:
Parametrised, registered magnitude comparator that drives an RGB status LED.
- Captures two WIDTH-bit operands on a valid strobe and classifies them: R = (a>=b), G = (b>=a), B = (a!=b).
- Applies a brightness/display mode to the LED outputs: steady, PWM-dimmed, blink or off.
- Keeps a saturating count of mismatched samples.
- Sits between switch/operand logic and the board RGB LED pins.

Parameters:
- WIDTH, 4, operand width in bits (>=1).
- PWM_BITS, 8, width of the PWM counter and of the duty input.
- BLINK_CYCLES, 25000000, clock cycles per blink half-period (>=1).
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe; a/b captured on any edge where it is 1.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- mode  in  2  00 steady, 01 PWM, 10 blink, 11 off.
- duty  in  PWM_BITS  PWM on-count per period, used in mode 01.
- clr_cnt  in  1  synchronous clear of mis_count.
- r  out  1  red LED = (a>=b), gated.
- g  out  1  green LED = (b>=a), gated.
- b_out  out  1  blue LED = (a!=b), gated.
- eq  out  1  a==b, ungated.
- out_valid  out  1  one-cycle pulse when r/g/b_out/eq reflect a new sample.
- mis_count  out  CNT_W  saturating count of accepted samples with a!=b.

Behaviour:
Interface
- One clock, clk. Reset rst is synchronous and active-high.
- No backpressure: the block is always ready.

Reset
- Applies on any edge where rst=1 and overrides all other inputs.
- Cleared to 0: r, g, b_out, eq, out_valid, mis_count, captured flags, pwm_cnt, blink_cnt.
- blink_phase is set to 1.

Capture
- Edge E0 with in_valid=1: flags ge=(a>=b), le=(b>=a), ne=(a!=b) are registered (unsigned compare, full WIDTH).
- If in_valid=0, the flags hold.

Output latency
- At E0+1: r=ge&gate, g=le&gate, b_out=ne&gate, eq=~ne; out_valid=1 for exactly that one cycle.
- Back-to-back in_valid gives one out_valid per sample, each one edge after its capture.
- r/g/b_out re-evaluate every edge from the current flags and gate, so gating changes show with one cycle of latency.

Gate by mode
- 00 (steady): gate=1.
- 01 (PWM): gate=(pwm_cnt < duty).
  - pwm_cnt is a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
  - duty=0: always off. duty=2^PWM_BITS-1: on for all but one count per period.
- 10 (blink): gate=blink_phase.
  - blink_cnt counts 0..BLINK_CYCLES-1; on the wrap, blink_phase toggles.
  - When mode!=10, blink_cnt is held at 0 and blink_phase at 1, so entering blink starts with a full ON half-period.
- 11 (off): gate=0.
- eq is never gated.

Counter
- On a capture edge with a!=b, mis_count increments, saturating at 2^CNT_W-1.
- clr_cnt=1 sets mis_count to 0; clear wins over a simultaneous increment.

Boundaries
- a=b: RGB=110, eq=1.
- a=all-ones, b=0: RGB=101.
- Mode change mid-sample affects gating only, never the flags.
- Reset on the edge after a capture suppresses that sample's out_valid and forces all outputs to 0.
- in_valid during reset is ignored.

Test Plan:
- Reset: rst=1 for 2 edges with in_valid=1, a=3, b=1 -> r=g=b_out=eq=out_valid=0, mis_count=0, no out_valid after release.
- Exhaustive steady: WIDTH=4, mode=00, all 256 (a,b) pairs back-to-back -> each out_valid carries r=(a>=b), g=(b>=a), b_out=(a!=b). Spot values: a=9,b=3 gives RGB=101; a=5,b=5 gives 110 with eq=1; a=0,b=15 gives 011.
- PWM: PWM_BITS=4, mode=01, a=2, b=7, duty=4 -> g and b_out high exactly 4 of every 16 cycles, r=0. duty=0 -> always 0. duty=15 -> high 15/16.
- Blink: BLINK_CYCLES=5, mode=10, a=b=0 -> r=g=1 for 5 cycles, 0 for 5, repeating, b_out=0, eq=1 throughout. Switching to 00 -> steady 110 after one edge.
- Counter: CNT_W=2, five mismatched samples -> mis_count 1,2,3,3,3. Then clr_cnt=1 coincident with a mismatched sample -> 0. A matched sample leaves the count unchanged.
- Reset mid-operation: in_valid with a=7, b=2, rst=1 on the next edge -> no out_valid, outputs 0, mis_count 0.
